// File: rtl/fft_r4_butterfly.sv
// fft_r4_butterfly: radix-4 DIF butterfly for the 64-point FFT datapath.
// Four complex IN_WIDTH samples per beat in, four OUT_WIDTH (= IN_WIDTH+2)
// full-precision results out, plus 4-beat group framing (beat index, group
// start pulse, sticky sync error) aligned with the data.
// Optional build macro FFT4_IN_REG_EN adds an input register stage on all
// data inputs, valid_in and ctrl_in (latency 3 instead of 2).
module fft_r4_butterfly #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = IN_WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 ctrl_in,
  input  logic [IN_WIDTH-1:0]  x_a_in,
  input  logic [IN_WIDTH-1:0]  y_a_in,
  input  logic [IN_WIDTH-1:0]  x_b_in,
  input  logic [IN_WIDTH-1:0]  y_b_in,
  input  logic [IN_WIDTH-1:0]  x_c_in,
  input  logic [IN_WIDTH-1:0]  y_c_in,
  input  logic [IN_WIDTH-1:0]  x_d_in,
  input  logic [IN_WIDTH-1:0]  y_d_in,
  input  logic                 err_clr,
  output logic [OUT_WIDTH-1:0] x_a_out,
  output logic [OUT_WIDTH-1:0] y_a_out,
  output logic [OUT_WIDTH-1:0] x_b_out,
  output logic [OUT_WIDTH-1:0] y_b_out,
  output logic [OUT_WIDTH-1:0] x_c_out,
  output logic [OUT_WIDTH-1:0] y_c_out,
  output logic [OUT_WIDTH-1:0] x_d_out,
  output logic [OUT_WIDTH-1:0] y_d_out,
  output logic                 valid_out,
  output logic                 ctrl_out,
  output logic [1:0]           beat_out,
  output logic                 sync_err
);

  localparam int S1_WIDTH = IN_WIDTH + 1;

  // Two bits of growth are exactly what four-input sums need; anything else
  // would either wrap or waste width downstream.
  if (OUT_WIDTH != IN_WIDTH + 2) begin : g_bad_width
    $error("fft_r4_butterfly: OUT_WIDTH must equal IN_WIDTH+2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Inputs gathered as arrays indexed a=0, b=1, c=2, d=3.
  logic signed [IN_WIDTH-1:0] raw_re [4];
  logic signed [IN_WIDTH-1:0] raw_im [4];

  assign raw_re[0] = x_a_in;
  assign raw_im[0] = y_a_in;
  assign raw_re[1] = x_b_in;
  assign raw_im[1] = y_b_in;
  assign raw_re[2] = x_c_in;
  assign raw_im[2] = y_c_in;
  assign raw_re[3] = x_d_in;
  assign raw_im[3] = y_d_in;

  // Beat as seen by the framing FSM and stage 1 (direct or registered).
  logic signed [IN_WIDTH-1:0] ev_re [4];
  logic signed [IN_WIDTH-1:0] ev_im [4];
  logic                       ev_valid;
  logic                       ev_ctrl;

`ifdef FFT4_IN_REG_EN
  logic signed [IN_WIDTH-1:0] in_re_d [4];
  logic signed [IN_WIDTH-1:0] in_im_d [4];
  logic signed [IN_WIDTH-1:0] in_re_q [4];
  logic signed [IN_WIDTH-1:0] in_im_q [4];
  logic                       in_valid_d, in_valid_q;
  logic                       in_ctrl_d, in_ctrl_q;

  // Input capture: ctrl is qualified by valid so a stray ctrl never survives.
  always_comb begin
    in_re_d    = raw_re;
    in_im_d    = raw_im;
    in_valid_d = valid_in;
    in_ctrl_d  = ctrl_in & valid_in;
  end

  // Input data register; data is not reset.
  always_ff @(posedge clk) begin
    in_re_q <= in_re_d;
    in_im_q <= in_im_d;
  end

  // Input flag register; flags are reset so no phantom beat appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_ctrl_q  <= 1'b0;
    end else begin
      in_valid_q <= in_valid_d;
      in_ctrl_q  <= in_ctrl_d;
    end
  end

  assign ev_re    = in_re_q;
  assign ev_im    = in_im_q;
  assign ev_valid = in_valid_q;
  assign ev_ctrl  = in_ctrl_q;
`else
  assign ev_re    = raw_re;
  assign ev_im    = raw_im;
  assign ev_valid = valid_in;
  assign ev_ctrl  = ctrl_in;
`endif

  // Framing state and stage-1 flag tags.
  state_t      state_d, state_q;
  logic [1:0]  cnt_d, cnt_q;
  logic        err_d, err_q;
  logic        err_evt;
  logic        s1_valid_d, s1_valid_q;
  logic        s1_ctrl_d, s1_ctrl_q;
  logic [1:0]  s1_beat_d, s1_beat_q;

  // Group FSM: tag each valid beat with its index, flag orphans and restarts.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_valid_d = ev_valid;
    s1_ctrl_d  = 1'b0;
    s1_beat_d  = s1_beat_q;
    err_evt    = 1'b0;
    if (ev_valid) begin
      s1_beat_d = 2'd0;
      if (ev_ctrl) begin
        // A start while a group is still open is a premature restart.
        err_evt   = (state_q == ST_RUN);
        state_d   = ST_RUN;
        cnt_d     = 2'd1;
        s1_ctrl_d = 1'b1;
      end else if (state_q == ST_IDLE) begin
        // Orphan beat: still processed, tagged as beat 0 without ctrl.
        err_evt = 1'b1;
      end else begin
        s1_beat_d = cnt_q;
        if (cnt_q == 2'd3) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    end
    // A new error beats a clear arriving on the same edge.
    if (err_evt) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // FSM, sticky error and stage-1 flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= 1'b0;
      s1_beat_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_ctrl_q  <= s1_ctrl_d;
      s1_beat_q  <= s1_beat_d;
    end
  end

  // Stage 1: s0=a+c, s1=a-c, s2=b+d, s3=b-d, one bit of growth.
  logic signed [S1_WIDTH-1:0] s_re_d [4];
  logic signed [S1_WIDTH-1:0] s_im_d [4];
  logic signed [S1_WIDTH-1:0] s_re_q [4];
  logic signed [S1_WIDTH-1:0] s_im_q [4];

  // Stage-1 sums and differences on sign-extended inputs.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s_re_d[2*i]   = S1_WIDTH'(ev_re[i]) + S1_WIDTH'(ev_re[i+2]);
      s_im_d[2*i]   = S1_WIDTH'(ev_im[i]) + S1_WIDTH'(ev_im[i+2]);
      s_re_d[2*i+1] = S1_WIDTH'(ev_re[i]) - S1_WIDTH'(ev_re[i+2]);
      s_im_d[2*i+1] = S1_WIDTH'(ev_im[i]) - S1_WIDTH'(ev_im[i+2]);
    end
  end

  // Stage-1 data register; data is not reset.
  always_ff @(posedge clk) begin
    s_re_q <= s_re_d;
    s_im_q <= s_im_d;
  end

  // Stage 2: X0=s0+s2, X1=s1-j*s3, X2=s0-s2, X3=s1+j*s3.
  logic signed [OUT_WIDTH-1:0] out_re_d [4];
  logic signed [OUT_WIDTH-1:0] out_im_d [4];
  logic signed [OUT_WIDTH-1:0] out_re_q [4];
  logic signed [OUT_WIDTH-1:0] out_im_q [4];
  logic                        out_valid_q, out_ctrl_q;
  logic [1:0]                  out_beat_q;

  // Stage-2 combination; multiplying by -j/+j is a swap with one negation.
  always_comb begin
    out_re_d[0] = OUT_WIDTH'(s_re_q[0]) + OUT_WIDTH'(s_re_q[2]);
    out_im_d[0] = OUT_WIDTH'(s_im_q[0]) + OUT_WIDTH'(s_im_q[2]);
    out_re_d[2] = OUT_WIDTH'(s_re_q[0]) - OUT_WIDTH'(s_re_q[2]);
    out_im_d[2] = OUT_WIDTH'(s_im_q[0]) - OUT_WIDTH'(s_im_q[2]);
    out_re_d[1] = OUT_WIDTH'(s_re_q[1]) + OUT_WIDTH'(s_im_q[3]);
    out_im_d[1] = OUT_WIDTH'(s_im_q[1]) - OUT_WIDTH'(s_re_q[3]);
    out_re_d[3] = OUT_WIDTH'(s_re_q[1]) - OUT_WIDTH'(s_im_q[3]);
    out_im_d[3] = OUT_WIDTH'(s_im_q[1]) + OUT_WIDTH'(s_re_q[3]);
  end

  // Output data register; data is not reset.
  always_ff @(posedge clk) begin
    out_re_q <= out_re_d;
    out_im_q <= out_im_d;
  end

  // Output flag register, travelling alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= 1'b0;
      out_beat_q  <= 2'd0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_ctrl_q  <= s1_ctrl_q;
      out_beat_q  <= s1_beat_q;
    end
  end

  assign x_a_out   = out_re_q[0];
  assign y_a_out   = out_im_q[0];
  assign x_b_out   = out_re_q[1];
  assign y_b_out   = out_im_q[1];
  assign x_c_out   = out_re_q[2];
  assign y_c_out   = out_im_q[2];
  assign x_d_out   = out_re_q[3];
  assign y_d_out   = out_im_q[3];
  assign valid_out = out_valid_q;
  assign ctrl_out  = out_ctrl_q;
  assign beat_out  = out_beat_q;
  assign sync_err  = err_q;

endmodule

// File: doc/fft_r4_butterfly.md
# fft_r4_butterfly

- Radix-4 DIF butterfly stage of the 64-point FFT datapath.
- Takes four complex 16-bit samples per beat and produces the four radix-4 outputs at 18-bit full precision, with 2 bits of growth and no scaling.
- Sits directly upstream of the twiddle multiplier, which consumes its 18-bit outputs and its group-start control pulse.
- Also tracks 4-beat groups, so the downstream twiddle ROM sequencing stays aligned, and flags group-sync errors.

## Interface
Parameters:
- IN_WIDTH, 16: input real/imag width (two's complement).
- OUT_WIDTH, IN_WIDTH+2: output real/imag width; must equal IN_WIDTH+2.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- valid_in, input, 1: the input beat is valid.
- ctrl_in, input, 1: first beat of a 4-beat group; only meaningful when valid_in=1.
- x_a_in, y_a_in … x_d_in, y_d_in, input, IN_WIDTH each: real/imag of inputs a,b,c,d.
- err_clr, input, 1: synchronous clear of sync_err.
- x_a_out, y_a_out … x_d_out, y_d_out, output, OUT_WIDTH each: X0..X3, registered.
- valid_out, output, 1: output beat is valid.
- ctrl_out, output, 1: group start, aligned with its data; drives the twiddle multiplier's ctrl_in.
- beat_out, output, 2: beat index 0..3 within the group, aligned with the data.
- sync_err, output, 1: sticky group-framing error.

## Operation
Arithmetic is signed two's complement throughout. Inputs are sign-extended and no intermediate saturates.

- Stage 1 (IN_WIDTH+1 bits per component):
  - s0=a+c, s1=a−c
  - s2=b+d, s3=b−d
- Stage 2 (OUT_WIDTH bits):
  - X0=s0+s2
  - X2=s0−s2
  - X1=(s1r+s3i, s1i−s3r), i.e. s1−j·s3
  - X3=(s1r−s3i, s1i+s3r), i.e. s1+j·s3
- Outputs map a←X0, b←X1, c←X2, d←X3.
- Worst case −2^(IN_WIDTH−1)·4 fits exactly in OUT_WIDTH; no overflow is possible.
- Data registers are not reset. Pipeline flags (valid, ctrl, beat) are reset.

Group FSM, with state IDLE or RUN and a 2-bit cnt; only beats with valid_in=1 are evaluated:
- IDLE + ctrl_in → RUN, cnt=1; beat tagged 0, ctrl tagged 1.
- IDLE + no ctrl_in (orphan beat) → data still processed and tagged beat 0, ctrl 0; sync_err set; stay IDLE.
- RUN + no ctrl_in:
  - beat tagged cnt; cnt increments.
  - After tagging beat 3 → IDLE, cnt=0.
- RUN + ctrl_in (premature restart) → sync_err set; beat tagged 0, ctrl 1; cnt=1; stay RUN.
- valid_in=0: state, cnt and tags hold; bubbles propagate as valid_out=0.
- Back-to-back groups: ctrl_in on the beat after beat 3 is legal (taken from IDLE) and raises no error.
- sync_err:
  - Set by the error events above.
  - Cleared by err_clr. When set and clear occur on the same edge, set wins.
  - Cleared by reset.

## Timing
- Latency is 2 cycles from a valid_in edge to valid_out/data, with 1 register per stage.
- ctrl_out, beat_out and valid_out travel in the same pipeline as the data, so they are exactly aligned.
- ctrl_out=ctrl_in&valid_in delayed by the latency. It is a 1-cycle pulse per accepted group start.
- Throughput is one beat per clock. There is no backpressure; the downstream stage always accepts.
- Reset values, applied asynchronously on rst_n low:
  - valid_out=0, ctrl_out=0, beat_out=0, sync_err=0.
  - FSM=IDLE, cnt=0.
  - Data outputs are undefined until the first valid beat emerges.
- Reset asserted mid-group:
  - In-flight valid/ctrl flags are dropped.
  - After release, the next ctrl_in starts a clean group.

## Configuration
- FFT4_IN_REG_EN defined:
  - An input register stage is added on all data inputs, valid_in and ctrl_in.
  - Latency becomes 3 cycles. The FSM evaluates the registered inputs.
- Undefined: inputs feed stage 1 directly and latency is 2.
- Functional results and flag alignment are identical in both builds.

## Test plan
- Impulse: a=(100,0), b=c=d=0, ctrl_in=1, valid_in=1 → after latency, all four outputs =(100,0); ctrl_out=1, beat_out=0.
- DC: a=b=c=d=(1000,0) → X0=(4000,0); X1=X2=X3=(0,0).
- j-rotation: b=(0,100), others 0 → X0=(0,100), X1=(100,0), X2=(0,−100), X3=(−100,0).
- Full-scale negative: all inputs real=−32768, imag 0 → X0 real=−131072; X1..X3=0; no wrap.
- Framing:
  - Run 4 valid beats from a ctrl_in, then a second group with a 1-cycle bubble → beat_out 0,1,2,3 then 0..3; valid_out shows the bubble; sync_err=0.
  - Then assert ctrl_in on beat 2 → sync_err=1 and beat_out restarts at 0.
  - err_clr → sync_err=0.
- Reset mid-group: drop rst_n after beat 1 → valid_out, ctrl_out and beat_out are 0 immediately. After release, a fresh ctrl_in gives beat_out 0..3 with sync_err=0.
